// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared types, codes and helpers for the pipeline hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
package hazard_pkg;

  // Tuse code for "this source register is not read"
  localparam logic [2:0] TUSE_NONE = 3'd7;

  // MDU busy lengths, used only when MDU_STALL_EN is defined
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  // Forwarding mux select codes
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  // MDU operation class seen in D
  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_HILO = 2'd3
  } md_op_e;

  // Shadow pipeline record carried through E, M and W
  typedef struct packed {
    logic [4:0] waddr;
    logic [2:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_rec_t;

  // Tnew counts down one per stage and sticks at zero
  function automatic logic [2:0] tnew_dec(input logic [2:0] t);
    return (t == 3'd0) ? 3'd0 : t - 3'd1;
  endfunction

  // Register 0 never matches anything
  function automatic logic reg_hit(input logic [4:0] waddr, input logic [4:0] src);
    return (src != 5'd0) && (waddr == src);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stage_reg.sv
`default_nettype none
// ============================================================================
// Module : hazard_stage_reg
// Brief  : One shadow pipeline record with async clear, bubble insertion and
//          optional saturating Tnew decrement on load.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter bit DEC_TNEW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bubble,
  input  stage_rec_t din,
  output stage_rec_t q
);

  stage_rec_t nxt;

  // Value to load: incoming record, Tnew aged by one stage when enabled
  always_comb begin
    nxt = din;
    if (DEC_TNEW) begin
      nxt.tnew = tnew_dec(din.tnew);
    end
  end

  // Record register; a bubble loads an all-zero (no-write) record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hazard_ctrl
// Brief  : Stall / forwarding scheduler for the 5-stage MIPS pipeline, driven
//          by Tuse/Tnew decode results and a private E/M/W shadow pipeline.
// Config : MDU_STALL_EN adds d_md_op and the multiply/divide busy stall.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [2:0] d_rs_tuse,
  input  logic [2:0] d_rt_tuse,
  input  logic [4:0] d_waddr,
  input  logic [2:0] d_tnew,
`ifdef MDU_STALL_EN
  input  logic [1:0] d_md_op,
`endif
  output logic       stall,
  output logic       pc_en,
  output logic       fd_en,
  output logic       e_flush,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       fwd_rt_m
);

  stage_rec_t d_rec;
  stage_rec_t e_rec;
  stage_rec_t m_rec;
  stage_rec_t w_rec;
  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;

  // Pack the D decode results as the record that enters E
  always_comb begin
    d_rec.waddr = d_waddr;
    d_rec.tnew  = d_tnew;
    d_rec.rs    = d_rs;
    d_rec.rt    = d_rt;
  end

  // E keeps Tnew as decoded; M and W age it by one per stage
  hazard_stage_reg #(.DEC_TNEW(1'b0)) u_rec_e (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (stall),
    .din    (d_rec),
    .q      (e_rec)
  );

  hazard_stage_reg #(.DEC_TNEW(1'b1)) u_rec_m (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .din    (e_rec),
    .q      (m_rec)
  );

  hazard_stage_reg #(.DEC_TNEW(1'b1)) u_rec_w (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .din    (m_rec),
    .q      (w_rec)
  );

  // Source-operand stalls: the producer in E or M is not ready by the time D needs it
  always_comb begin
    stall_rs = (d_rs_tuse != TUSE_NONE) &&
               ((reg_hit(e_rec.waddr, d_rs) && (e_rec.tnew > d_rs_tuse)) ||
                (reg_hit(m_rec.waddr, d_rs) && (m_rec.tnew > d_rs_tuse)));
    stall_rt = (d_rt_tuse != TUSE_NONE) &&
               ((reg_hit(e_rec.waddr, d_rt) && (e_rec.tnew > d_rt_tuse)) ||
                (reg_hit(m_rec.waddr, d_rt) && (m_rec.tnew > d_rt_tuse)));
  end

`ifdef MDU_STALL_EN
  logic [1:0] e_md_op;
  logic [3:0] busy;
  logic       start_e;

  assign start_e = (e_md_op == MD_MULT) || (e_md_op == MD_DIV);

  // MDU class rides alongside the E record and is bubbled the same way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_md_op <= MD_NONE;
    end else if (stall) begin
      e_md_op <= MD_NONE;
    end else begin
      e_md_op <= d_md_op;
    end
  end

  // Busy counter starts when a mult/div leaves E, then counts down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 4'd0;
    end else if (start_e) begin
      busy <= (e_md_op == MD_MULT) ? 4'(MULT_CYC) : 4'(DIV_CYC);
    end else if (busy != 4'd0) begin
      busy <= busy - 4'd1;
    end
  end

  // Any MDU access in D waits while a mult/div is in E or still busy
  always_comb begin
    stall_md = (d_md_op != MD_NONE) && ((busy != 4'd0) || start_e);
  end
`else
  // No MDU interlock in this build
  always_comb begin
    stall_md = 1'b0;
  end
`endif

  // Stall fans out to the front-end enables and the D/E bubble
  always_comb begin
    stall   = stall_rs | stall_rt | stall_md;
    pc_en   = ~stall;
    fd_en   = ~stall;
    e_flush = stall;
  end

  // D forwarding: youngest ready producer wins, E > M > W
  always_comb begin
    fwd_rs_d = FWD_GRF;
    if (reg_hit(e_rec.waddr, d_rs) && (e_rec.tnew == 3'd0)) begin
      fwd_rs_d = FWD_E;
    end else if (reg_hit(m_rec.waddr, d_rs) && (m_rec.tnew == 3'd0)) begin
      fwd_rs_d = FWD_M;
    end else if (reg_hit(w_rec.waddr, d_rs) && (w_rec.tnew == 3'd0)) begin
      fwd_rs_d = FWD_W;
    end
    fwd_rt_d = FWD_GRF;
    if (reg_hit(e_rec.waddr, d_rt) && (e_rec.tnew == 3'd0)) begin
      fwd_rt_d = FWD_E;
    end else if (reg_hit(m_rec.waddr, d_rt) && (m_rec.tnew == 3'd0)) begin
      fwd_rt_d = FWD_M;
    end else if (reg_hit(w_rec.waddr, d_rt) && (w_rec.tnew == 3'd0)) begin
      fwd_rt_d = FWD_W;
    end
  end

  // E forwarding from M then W, and M store-data forwarding from W
  always_comb begin
    fwd_rs_e = FWD_GRF;
    if (reg_hit(m_rec.waddr, e_rec.rs) && (m_rec.tnew == 3'd0)) begin
      fwd_rs_e = FWD_M;
    end else if (reg_hit(w_rec.waddr, e_rec.rs) && (w_rec.tnew == 3'd0)) begin
      fwd_rs_e = FWD_W;
    end
    fwd_rt_e = FWD_GRF;
    if (reg_hit(m_rec.waddr, e_rec.rt) && (m_rec.tnew == 3'd0)) begin
      fwd_rt_e = FWD_M;
    end else if (reg_hit(w_rec.waddr, e_rec.rt) && (w_rec.tnew == 3'd0)) begin
      fwd_rt_e = FWD_W;
    end
    fwd_rt_m = reg_hit(w_rec.waddr, m_rec.rt) && (w_rec.tnew == 3'd0);
  end

  // Source fields of the later records are carried for uniformity only
  logic unused_rec_bits;
  assign unused_rec_bits = ^{m_rec.rs, w_rec.rs, w_rec.rt};

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_ctrl
// Brief  : Directed self-checking bench for hazard_ctrl.
// Config : MDU_STALL_EN enables the mult/mfhi busy-stall vector.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam logic [2:0] TN = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] d_rs, d_rt, d_waddr;
  logic [2:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic [1:0] d_md_op;
  logic       stall, pc_en, fd_en, e_flush, fwd_rt_m;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_rs_tuse (d_rs_tuse),
    .d_rt_tuse (d_rt_tuse),
    .d_waddr   (d_waddr),
    .d_tnew    (d_tnew),
`ifdef MDU_STALL_EN
    .d_md_op   (d_md_op),
`endif
    .stall     (stall),
    .pc_en     (pc_en),
    .fd_en     (fd_en),
    .e_flush   (e_flush),
    .fwd_rs_d  (fwd_rs_d),
    .fwd_rt_d  (fwd_rt_d),
    .fwd_rs_e  (fwd_rs_e),
    .fwd_rt_e  (fwd_rt_e),
    .fwd_rt_m  (fwd_rt_m)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [2:0] rs_tuse,
                       input logic [4:0] rt, input logic [2:0] rt_tuse,
                       input logic [4:0] waddr, input logic [2:0] tnew);
    d_rs = rs; d_rs_tuse = rs_tuse; d_rt = rt; d_rt_tuse = rt_tuse;
    d_waddr = waddr; d_tnew = tnew;
  endtask

  task automatic nop();
    drive(5'd0, TN, 5'd0, TN, 5'd0, 3'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop(); tick(); tick(); tick();
  endtask

  initial begin
    d_md_op = 2'd0;
    rst_n = 1'b0;
    drive(5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0);
    #12;
    chk("rst_stall", {7'd0, stall}, 8'd0);
    chk("rst_pc_en", {7'd0, pc_en}, 8'd1);
    chk("rst_fd_en", {7'd0, fd_en}, 8'd1);
    chk("rst_flush", {7'd0, e_flush}, 8'd0);
    chk("rst_fwd", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}, 8'd0);
    chk("rst_fwd_m", {7'd0, fwd_rt_m}, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_stall", {7'd0, stall}, 8'd0);
    chk("rel_pc_en", {7'd0, pc_en}, 8'd1);
    chk("rel_fwd", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e}, 8'd0);

    // lw $2 then beq on $2: two stall cycles, then W forward
    drive(5'd0, TN, 5'd0, TN, 5'd2, 3'd2);
    #1 chk("lw_nostall", {7'd0, stall}, 8'd0);
    tick();
    drive(5'd2, 3'd0, 5'd0, TN, 5'd0, 3'd0);
    #1 chk("beq_stall1", {7'd0, stall}, 8'd1);
    chk("beq_pc_en1", {7'd0, pc_en}, 8'd0);
    chk("beq_flush1", {7'd0, e_flush}, 8'd1);
    tick();
    chk("beq_stall2", {7'd0, stall}, 8'd1);
    tick();
    chk("beq_stall3", {7'd0, stall}, 8'd0);
    chk("beq_fwd_w", {6'd0, fwd_rs_d}, 8'd3);
    tick();
    drain();

    // add $3 then add $4,$3,$3: no stall, E then M forwarding
    drive(5'd0, TN, 5'd0, TN, 5'd3, 3'd1);
    tick();
    drive(5'd3, 3'd1, 5'd3, 3'd1, 5'd4, 3'd1);
    #1 chk("add_nostall", {7'd0, stall}, 8'd0);
    chk("add_fwd_d", {6'd0, fwd_rs_d}, 8'd0);
    tick();
    nop();
    #1 chk("add_fwd_rs_e", {6'd0, fwd_rs_e}, 8'd2);
    chk("add_fwd_rt_e", {6'd0, fwd_rt_e}, 8'd2);
    tick();
    chk("add_fwd_rt_m", {7'd0, fwd_rt_m}, 8'd1);
    drain();

    // jal then jr $31: no stall, forward from E
    drive(5'd0, TN, 5'd0, TN, 5'd31, 3'd0);
    tick();
    drive(5'd31, 3'd0, 5'd0, TN, 5'd0, 3'd0);
    #1 chk("jr_nostall", {7'd0, stall}, 8'd0);
    chk("jr_fwd_e", {6'd0, fwd_rs_d}, 8'd1);
    drain();

    // write to $0 with tnew=2, then a reader of $0: never a hazard
    drive(5'd0, TN, 5'd0, TN, 5'd0, 3'd2);
    tick();
    drive(5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0);
    #1 chk("r0_stall", {7'd0, stall}, 8'd0);
    chk("r0_fwd", {fwd_rs_d, fwd_rt_d}, 8'd0);
    drain();

    // lw $5 then a reader of rt=$5 at tuse=1: one stall cycle, no early forward
    drive(5'd0, TN, 5'd0, TN, 5'd5, 3'd2);
    tick();
    drive(5'd0, TN, 5'd5, 3'd1, 5'd0, 3'd0);
    #1 chk("rt_stall1", {7'd0, stall}, 8'd1);
    chk("rt_fd_en1", {7'd0, fd_en}, 8'd0);
    tick();
    chk("rt_stall2", {7'd0, stall}, 8'd0);
    chk("rt_fwd_d", {6'd0, fwd_rt_d}, 8'd0);
    tick();
    chk("rt_fwd_w", {6'd0, fwd_rt_d}, 8'd3);
    drain();

    // asynchronous reset in the middle of a load-use stall
    drive(5'd0, TN, 5'd0, TN, 5'd6, 3'd2);
    tick();
    drive(5'd6, 3'd0, 5'd0, TN, 5'd0, 3'd0);
    #1 chk("ar_stall_pre", {7'd0, stall}, 8'd1);
    rst_n = 1'b0;
    #1 chk("ar_stall", {7'd0, stall}, 8'd0);
    chk("ar_pc_en", {7'd0, pc_en}, 8'd1);
    chk("ar_flush", {7'd0, e_flush}, 8'd0);
    nop();
    tick();
    rst_n = 1'b1;
    tick();

`ifdef MDU_STALL_EN
    // mult then mfhi: stall for 1 + 5 cycles
    begin
      int n;
      d_md_op = 2'd1;
      tick();
      d_md_op = 2'd3;
      #1;
      n = 0;
      while (stall && n < 20) begin
        n++;
        tick();
      end
      chk("md_stall_len", n[7:0], 8'd6);
      chk("md_release", {7'd0, stall}, 8'd0);
      d_md_op = 2'd0;
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
